// File: rtl/conv_accum.sv
// conv_accum: sums TAPS products, adds bias, rounds, shifts and saturates to int8.
// Optional macro RELU_EN clamps negative activations to zero.
module conv_accum #(
    parameter int TAPS   = 9,
    parameter int PROD_W = 16,
    parameter int BIAS_W = 16,
    parameter int ACC_W  = 24,
    parameter int SHIFT  = 7
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      clear,
    input  logic                      prod_valid,
    input  logic signed [PROD_W-1:0]  prod,
    output logic                      in_ready,
    input  logic signed [BIAS_W-1:0]  bias,
    output logic                      out_valid,
    output logic [7:0]                out_data,
    input  logic                      out_ready,
    output logic [$clog2(TAPS)-1:0]   tap_cnt
);

    localparam int TW = $clog2(TAPS);

    localparam logic [1:0] ACCUM = 2'd0;
    localparam logic [1:0] BIAS  = 2'd1;
    localparam logic [1:0] SCALE = 2'd2;
    localparam logic [1:0] OUT   = 2'd3;

    localparam int RNDI = 1 << (SHIFT - 1);
    localparam logic signed [ACC_W:0] RND  = (ACC_W+1)'(RNDI);
    localparam logic signed [ACC_W:0] MAXV = (ACC_W+1)'(127);
    localparam logic signed [ACC_W:0] MINV = -(ACC_W+1)'(128);

    logic [1:0]              state;
    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] prod_x;
    logic signed [ACC_W-1:0] bias_x;
    logic signed [ACC_W:0]   rsum;
    logic signed [ACC_W:0]   r;
    logic [7:0]              sat;
    logic                    accept;
    logic                    last;

    assign in_ready = (state == ACCUM);
    assign accept   = prod_valid && in_ready;
    assign last     = (tap_cnt == TW'(TAPS - 1));

    assign prod_x = {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod};
    assign bias_x = {{(ACC_W-BIAS_W){bias[BIAS_W-1]}}, bias};

    // One extra bit keeps the rounding add from wrapping near full scale
    assign rsum = {acc[ACC_W-1], acc} + RND;
    assign r    = rsum >>> SHIFT;

    always_comb begin
        sat = r[7:0];
`ifdef RELU_EN
        if (r[ACC_W])
            sat = 8'h00;
        else if (r > MAXV)
            sat = 8'h7f;
`else
        if (r > MAXV)
            sat = 8'h7f;
        else if (r < MINV)
            sat = 8'h80;
`endif
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= ACCUM;
            acc       <= '0;
            tap_cnt   <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (clear) begin
            state     <= ACCUM;
            acc       <= '0;
            tap_cnt   <= '0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                ACCUM: begin
                    if (accept) begin
                        acc <= acc + prod_x;
                        if (last) begin
                            tap_cnt <= '0;
                            state   <= BIAS;
                        end else begin
                            tap_cnt <= tap_cnt + 1'b1;
                        end
                    end
                end
                BIAS: begin
                    acc   <= acc + bias_x;
                    state <= SCALE;
                end
                SCALE: begin
                    out_data  <= sat;
                    out_valid <= 1'b1;
                    state     <= OUT;
                end
                OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        acc       <= '0;
                        state     <= ACCUM;
                    end
                end
                default: state <= ACCUM;
            endcase
        end
    end

endmodule

// File: tb/tb_conv_accum.sv
// tb_conv_accum: directed windows checked against a window-level model of conv_accum.
// Follows RELU_EN when the macro is defined for the build.
module tb_conv_accum;

    localparam int TAPS = 9;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              clear = 1'b0;
    logic              prod_valid = 1'b0;
    logic signed [15:0] prod = '0;
    logic              in_ready;
    logic signed [15:0] bias = '0;
    logic              out_valid;
    logic [7:0]        out_data;
    logic              out_ready = 1'b1;
    logic [3:0]        tap_cnt;

    int  errors = 0;
    int  checks = 0;
    bit  checking = 1'b0;

    int     m_cnt = 0;
    int     m_lat = 0;
    int     m_od = 0;
    bit     m_busy = 1'b0;
    bit     m_ov = 1'b0;
    longint m_sum = 0;

    conv_accum dut (
        .clk(clk),
        .reset(reset),
        .clear(clear),
        .prod_valid(prod_valid),
        .prod(prod),
        .in_ready(in_ready),
        .bias(bias),
        .out_valid(out_valid),
        .out_data(out_data),
        .out_ready(out_ready),
        .tap_cnt(tap_cnt)
    );

    always #5 clk = ~clk;

    function automatic int act8(input longint s);
        longint t;
        longint q;
        t = s + 64;
        q = t / 128;
        if ((t % 128) != 0 && t < 0)
            q = q - 1;
`ifdef RELU_EN
        if (q < 0) return 0;
`else
        if (q < -128) return -128;
`endif
        if (q > 127) return 127;
        return int'(q);
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Window-level reference: sum products, add bias, emit result, wait for the handshake
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_cnt = 0; m_sum = 0; m_busy = 0; m_ov = 0; m_lat = 0; m_od = 0;
        end else if (clear) begin
            m_cnt = 0; m_sum = 0; m_busy = 0; m_ov = 0; m_lat = 0;
        end else if (!m_busy) begin
            if (prod_valid) begin
                m_sum += prod;
                m_cnt++;
                if (m_cnt == TAPS) begin
                    m_cnt = 0; m_busy = 1; m_lat = 0;
                end
            end
        end else if (m_ov) begin
            if (out_ready) begin
                m_ov = 0; m_busy = 0; m_sum = 0;
            end
        end else begin
            m_lat++;
            if (m_lat == 1) begin
                m_sum += bias;
            end else begin
                m_od = act8(m_sum);
                m_ov = 1;
            end
        end
    end

    always @(negedge clk) begin
        if (checking) begin
            chk("in_ready", int'(in_ready), int'(!m_busy));
            chk("tap_cnt", int'(tap_cnt), m_cnt);
            chk("out_valid", int'(out_valid), int'(m_ov));
            chk("out_data", int'($signed(out_data)), m_od);
        end
    end

    // Called at posedge+1; returns at posedge+1 after the n-th accept
    task automatic push(input int v, input int n);
        int k;
        int g;
        k = 0;
        g = 0;
        prod = 16'(v);
        prod_valid = 1'b1;
        while (k < n && g < 200) begin
            @(negedge clk);
            if (in_ready) k++;
            @(posedge clk);
            #1;
            g++;
        end
        prod_valid = 1'b0;
        chk("push_done", k, n);
    endtask

    task automatic wait_out(output int lat);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!out_valid && lat < 30);
        chk("out_valid_seen", int'(out_valid), 1);
    endtask

    task automatic window(input string name, input int v, input int b, input int exp);
        int lat;
        bias = 16'(b);
        push(v, TAPS);
        wait_out(lat);
        chk({name, "_lat"}, lat, 3);
        chk(name, int'($signed(out_data)), exp);
        chk({name, "_model"}, m_od, exp);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int lat;
        #2 reset = 1'b0;
        checking = 1'b1;
        #1;
        chk("rst_in_ready", int'(in_ready), 1);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_tap_cnt", int'(tap_cnt), 0);
        chk("rst_out_data", int'(out_data), 0);
        @(posedge clk);
        #1 reset = 1'b1;

        window("w_100", 100, 28, 7);
        window("w_sat", 16129, 0, 127);
`ifdef RELU_EN
        window("w_neg", -110, 0, 0);
`else
        window("w_neg", -110, 0, -8);
`endif

        // Backpressure with upstream still offering products
        out_ready = 1'b0;
        bias = 16'sd28;
        push(100, TAPS);
        prod = 16'sd5;
        prod_valid = 1'b1;
        wait_out(lat);
        repeat (5) begin
            @(negedge clk);
            chk("bp_valid", int'(out_valid), 1);
            chk("bp_data", int'($signed(out_data)), 7);
            chk("bp_in_ready", int'(in_ready), 0);
            chk("bp_tap_cnt", int'(tap_cnt), 0);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
        @(negedge clk);
        chk("bp_hold_until_edge", int'(out_valid), 1);
        chk("bp_no_accept", int'(tap_cnt), 0);
        @(negedge clk);
        chk("bp_after_hs_valid", int'(out_valid), 0);
        chk("bp_after_hs_ready", int'(in_ready), 1);
        chk("bp_after_hs_cnt", int'(tap_cnt), 0);
        @(negedge clk);
        chk("bp_first_accept", int'(tap_cnt), 1);
        @(posedge clk);
        #1;
        push(5, TAPS - 2);
        wait_out(lat);
        chk("w_bp_next", int'($signed(out_data)), 1);
        @(posedge clk);
        #1;

        // Asynchronous reset in the middle of a window
        bias = 16'sd28;
        push(100, 4);
        chk("pre_rst_cnt", int'(tap_cnt), 4);
        #2 reset = 1'b0;
        #1;
        chk("arst_in_ready", int'(in_ready), 1);
        chk("arst_tap_cnt", int'(tap_cnt), 0);
        chk("arst_out_valid", int'(out_valid), 0);
        chk("arst_out_data", int'(out_data), 0);
        @(posedge clk);
        #1 reset = 1'b1;
        window("w_after_rst", 100, 28, 7);

        // Synchronous clear with a concurrent product
        push(100, 5);
        clear = 1'b1;
        prod = 16'sd100;
        prod_valid = 1'b1;
        @(posedge clk);
        #1;
        clear = 1'b0;
        prod_valid = 1'b0;
        @(negedge clk);
        chk("clr_tap_cnt", int'(tap_cnt), 0);
        chk("clr_in_ready", int'(in_ready), 1);
        @(posedge clk);
        #1;
        window("w_after_clr", 100, 28, 7);

        repeat (3) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
